msdft_bram_writer: RTL and testbench
====================================

MSDFT_BRAM_WRITER -- requirements
Module: msdft_bram_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of a correlator sample and a BRAM word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning BRAM address width; one capture is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter DEC_WIDTH, default 8, meaning width of the decimation factor input.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-005 SHALL have port clk, input, 1, meaning single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port din, input, DATA_WIDTH, meaning correlator output sample.
REQ-008 SHALL have port din_valid, input, 1, meaning din is valid this cycle (no backpressure).
REQ-009 SHALL have port sync_in, input, 1, meaning frame-start marker, qualified by din_valid.
REQ-010 SHALL have port arm, input, 1, meaning request a new capture (level sampled per cycle).
REQ-011 SHALL have port abort, input, 1, meaning cancel capture and return to IDLE.
REQ-012 SHALL have port dec_factor, input, DEC_WIDTH, meaning keep 1 of every dec_factor valid samples; 0 is treated as 1.
REQ-013 SHALL have port bram_addr, output, ADDR_WIDTH, meaning write address to BRAM fpga port.
REQ-014 SHALL have port bram_din, output, DATA_WIDTH, meaning write data to BRAM fpga port.
REQ-015 SHALL have port bram_we, output, 1, meaning one-cycle write strobe.
REQ-016 SHALL have port busy, output, 1, meaning state is WAIT_SYNC or CAPTURE.
REQ-017 SHALL have port done, output, 1, meaning capture complete; held until re-arm, abort or reset.

Function
REQ-018 SHALL implement states IDLE, WAIT_SYNC, CAPTURE, DONE.
REQ-019 IDLE or DONE with arm=1 SHALL go to WAIT_SYNC next cycle, latch dec_factor (0 -> 1), clear write pointer and decimation counter, and deassert done.
REQ-020 WAIT_SYNC SHALL ignore sync_in while din_valid=0; on sync_in=1 and din_valid=1, that sample SHALL be written to address 0 and the state SHALL go to CAPTURE.
REQ-021 CAPTURE SHALL count every din_valid sample; a sample SHALL be written when the decimation counter equals 0, the counter wrapping from latched_dec-1 to 0 (sync sample counts as counter 0).
REQ-022 Writes SHALL have latency 1: bram_we, bram_addr and bram_din registered the cycle after the accepted sample; bram_we high exactly one cycle per written sample.
REQ-023 Write pointer SHALL increment by 1 after each write; addresses SHALL be written strictly 0,1,...,2**ADDR_WIDTH-1 with no gaps and no repeats.
REQ-024 After the write to address 2**ADDR_WIDTH-1 is issued, the state SHALL go to DONE and done SHALL assert in the same cycle as that bram_we; no further writes until re-armed.
REQ-025 arm SHALL be ignored in WAIT_SYNC and CAPTURE; sync_in SHALL be ignored in CAPTURE, DONE and IDLE.
REQ-026 abort=1 in any state SHALL go to IDLE next cycle, suppress any write for the sample of that cycle, and clear done; abort SHALL win over simultaneous arm.
REQ-027 dec_factor changes after arming SHALL have no effect until the next arm.
REQ-028 busy SHALL be a registered decode of the state.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0, pointer and decimation counter 0.
REQ-030 Reset mid-capture SHALL discard the capture; after release, no write SHALL occur until a new arm and sync.

Verification (ADDR_WIDTH=3, DATA_WIDTH=16)
REQ-031 arm, dec_factor=1, sync with din=0x100 then continuous valid 0x101..0x107 -> writes addr 0..7 data 0x100..0x107, done with 8th bram_we, busy low next cycle.
REQ-032 dec_factor=3, sync at din=0, then valid ramp 1..30 -> writes data 0,3,6,...,21 at addr 0..7.
REQ-033 sync_in=1 with din_valid=0, then sync with valid din=0x55 -> first write data 0x55 at addr 0; gapped din_valid produces no extra writes.
REQ-034 abort after 4 writes, simultaneous arm -> IDLE, no further bram_we, done=0; new arm+sync restarts at addr 0.
REQ-035 rst_n asserted after 5 writes -> all outputs 0 asynchronously; no writes after release without arm.
REQ-036 arm held high across full capture and DONE -> re-arm only from DONE; second capture writes addr 0..7 again; dec_factor=0 behaves as 1.

Source files
------------

// File: rtl/msdft_bram_writer.sv
// ----------------------------------------------------------------------------
// msdft_bram_writer
//
// Captures one frame of correlator samples into a BRAM through its FPGA-side
// write port. A capture is started by arm and begins at the next valid sample
// that carries sync_in. From then on, one of every dec_factor valid samples is
// written. Writes go to consecutive addresses 0 .. 2**ADDR_WIDTH-1, then the
// block stops and holds done until it is re-armed, aborted or reset.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         correlator sample (DATA_WIDTH)
//   din_valid   din is valid this cycle; there is no backpressure
//   sync_in     frame-start marker, qualified by din_valid
//   arm         request a new capture (level, sampled every cycle)
//   abort       cancel the capture and return to IDLE; wins over arm
//   dec_factor  keep 1 of every dec_factor valid samples; 0 acts as 1
//   bram_addr   BRAM write address (ADDR_WIDTH)
//   bram_din    BRAM write data (DATA_WIDTH)
//   bram_we     BRAM write strobe, one cycle per written sample
//   busy        registered decode: state is WAIT_SYNC or CAPTURE
//   done        capture complete
//
// State       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | no capture in progress; waiting for arm
// S_WAIT_SYNC | armed; waiting for a valid sample that carries sync_in
// S_CAPTURE   | writing decimated samples to consecutive addresses
// S_DONE      | last address written; done held until re-armed or aborted
// ----------------------------------------------------------------------------
module msdft_bram_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEC_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  sync_in,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DEC_WIDTH-1:0]  dec_factor,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [DEC_WIDTH-1:0]  DEC_ONE   = DEC_WIDTH'(1);

    state_t                state;
    logic [DEC_WIDTH-1:0]  dec_latched;
    logic [DEC_WIDTH-1:0]  dec_cnt;
    logic [DEC_WIDTH-1:0]  dec_cnt_next;
    logic [ADDR_WIDTH-1:0] wr_ptr;

    // Decimation counter runs 0 .. dec_latched-1; a sample is kept at 0.
    always_comb begin
        dec_cnt_next = dec_cnt + DEC_ONE;
        if (dec_cnt == dec_latched - DEC_ONE) begin
            dec_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dec_latched <= DEC_ONE;
            dec_cnt     <= '0;
            wr_ptr      <= '0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            done        <= 1'b0;
        end else begin
            bram_we <= 1'b0;
            if (abort) begin
                // The sample of this cycle is dropped: bram_we stays low.
                state <= S_IDLE;
                done  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            state       <= S_WAIT_SYNC;
                            dec_latched <= (dec_factor == '0) ? DEC_ONE : dec_factor;
                            dec_cnt     <= '0;
                            wr_ptr      <= '0;
                            done        <= 1'b0;
                        end
                    end
                    S_WAIT_SYNC: begin
                        // The sync sample itself is decimation slot 0.
                        if (din_valid && sync_in) begin
                            bram_we   <= 1'b1;
                            bram_addr <= wr_ptr;
                            bram_din  <= din;
                            wr_ptr    <= wr_ptr + 1'b1;
                            dec_cnt   <= dec_cnt_next;
                            state     <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (din_valid) begin
                            if (dec_cnt == '0) begin
                                bram_we   <= 1'b1;
                                bram_addr <= wr_ptr;
                                bram_din  <= din;
                                wr_ptr    <= wr_ptr + 1'b1;
                                // done rises together with the final strobe.
                                if (wr_ptr == LAST_ADDR) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end
                            end
                            dec_cnt <= dec_cnt_next;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Registered decode of the state, so it trails the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state == S_WAIT_SYNC) || (state == S_CAPTURE);
        end
    end

endmodule

// File: tb/tb_msdft_bram_writer.sv
module tb_msdft_bram_writer;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          sync_in;
    logic          arm;
    logic          abort;
    logic [CW-1:0] dec_factor;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we;
    logic          busy;
    logic          done;

    msdft_bram_writer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEC_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sync_in   (sync_in),
        .arm       (arm),
        .abort     (abort),
        .dec_factor(dec_factor),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          dn;
    } wr_t;

    wr_t exp_q[$];
    int  checks      = 0;
    int  failures    = 0;
    int  pushes      = 0;
    int  writes_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input int d, input bit dn);
        wr_t e;
        e.addr = a[AW-1:0];
        e.data = d[DW-1:0];
        e.dn   = dn;
        exp_q.push_back(e);
        pushes++;
    endtask

    task automatic step(input logic v, input logic s, input logic [DW-1:0] d,
                        input logic a, input logic ab);
        din_valid = v;
        sync_in   = s;
        din       = d;
        arm       = a;
        abort     = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bram_we) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0d data=0x%0h", bram_addr, bram_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bram_addr, e.addr);
                chk("wr_data", bram_din, e.data);
                chk("wr_done", done, e.dn);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        sync_in    = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        dec_factor = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", bram_we, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_din", bram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // Test 1: dec 1, sync sample then continuous ramp.
        dec_factor = 8'd1;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            push(i, 16'h100 + i, i == 7);
            step(1, i == 0, 16'(16'h100 + i), 0, 0);
        end
        chk("t1_done_with_last_we", done, 1);
        chk("t1_busy_at_last_we", busy, 1);
        step(0, 0, 0, 0, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_done_held", done, 1);
        drain("t1_drain");

        // Test 2: dec 3; dec_factor change after arm has no effect; sync ignored mid-capture.
        dec_factor = 8'd3;
        step(0, 0, 0, 1, 0);
        dec_factor = 8'd5;
        push(0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            if (k % 3 == 0 && k <= 21) push(k / 3, k, k == 21);
            step(1, k == 10, 16'(k), 0, 0);
        end
        step(0, 0, 0, 0, 0);
        drain("t2_drain");
        chk("t2_done", done, 1);

        // Test 3: sync without valid ignored; gapped valid.
        dec_factor = 8'd1;
        step(0, 0, 0, 1, 0);
        chk("t3_done_cleared_by_arm", done, 0);
        step(0, 1, 16'h99, 0, 0);
        step(1, 0, 16'h77, 0, 0);
        push(0, 16'h55, 0);
        step(1, 1, 16'h55, 0, 0);
        for (int j = 1; j < 8; j++) begin
            step(0, 0, 16'hEEEE, 0, 0);
            push(j, 16'h55 + j, j == 7);
            step(1, 0, 16'(16'h55 + j), 0, 0);
        end
        step(0, 0, 0, 0, 0);
        drain("t3_drain");
        chk("t3_done", done, 1);

        // Test 4: abort with simultaneous arm after 4 writes, then restart.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            push(i, 16'h200 + i, 0);
            step(1, i == 0, 16'(16'h200 + i), 0, 0);
        end
        step(1, 0, 16'h204, 1, 1);
        chk("t4_done_after_abort", done, 0);
        chk("t4_no_we_on_abort", bram_we, 0);
        step(1, 1, 16'h205, 0, 0);
        step(1, 1, 16'h206, 0, 0);
        chk("t4_busy_idle", busy, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            push(i, 16'h300 + i, i == 7);
            step(1, i == 0, 16'(16'h300 + i), 0, 0);
        end
        step(0, 0, 0, 0, 0);
        drain("t4_drain");

        // Test 5: asynchronous reset right after the 5th write.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            push(i, 16'h600 + i, 0);
            step(1, i == 0, 16'(16'h600 + i), 0, 0);
        end
        step(1, 0, 16'h604, 0, 0);
        chk("t5_we5", bram_we, 1);
        chk("t5_addr5", bram_addr, 4);
        chk("t5_data5", bram_din, 16'h604);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_we", bram_we, 0);
        chk("t5_async_addr", bram_addr, 0);
        chk("t5_async_din", bram_din, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_done", done, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1, 1, 16'(16'h700 + i), 0, 0);
        drain("t5_drain");
        chk("t5_busy_no_arm", busy, 0);

        // Test 6: arm held high throughout; dec_factor 0 acts as 1.
        dec_factor = 8'd0;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            push(i, 16'h400 + i, i == 7);
            step(1, i == 0, 16'(16'h400 + i), 1, 0);
        end
        chk("t6_done_first", done, 1);
        step(0, 0, 0, 1, 0);
        chk("t6_done_rearm", done, 0);
        chk("t6_busy_in_done", busy, 0);
        step(0, 0, 0, 1, 0);
        chk("t6_busy_rearmed", busy, 1);
        for (int i = 0; i < 8; i++) begin
            push(i, 16'h500 + i, i == 7);
            step(1, i == 0, 16'(16'h500 + i), 0, 0);
        end
        step(0, 0, 0, 0, 0);
        drain("t6_drain");
        chk("t6_done_second", done, 1);

        chk("total_writes", writes_seen, pushes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
